// File: rtl/simd_pkg.sv
// Shared types and default sizes for the pipelined SIMD array.
package simd_pkg;

  localparam int DEF_UNIT_SIZE = 32;
  localparam int DEF_LANES     = 8;
  localparam int DEF_MAT_DIM   = 3;

  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_MATVEC  = 3'd2,
    OP_ACC     = 3'd3,
    OP_ACC_CLR = 3'd4
  } opcode_t;

  typedef enum logic {
    IDLE = 1'b0,
    MV   = 1'b1
  } state_t;

endpackage

// File: rtl/simd_dot_row.sv
// One matrix row dotted with the operand vector; products and sum wrap to UNIT_SIZE.
module simd_dot_row #(
  parameter int UNIT_SIZE = 32,
  parameter int MAT_DIM   = 3
) (
  input  logic [MAT_DIM-1:0][UNIT_SIZE-1:0] row,
  input  logic [MAT_DIM-1:0][UNIT_SIZE-1:0] vec,
  output logic [UNIT_SIZE-1:0]              dot
);

  logic [MAT_DIM-1:0][UNIT_SIZE-1:0] prod;

  for (genvar c = 0; c < MAT_DIM; c++) begin : g_mul
    assign prod[c] = row[c] * vec[c];
  end

  always_comb begin
    dot = '0;
    for (int c = 0; c < MAT_DIM; c++) dot = dot + prod[c];
  end

endmodule

// File: rtl/simd_arr_pipe.sv
// Registered, handshaked SIMD array: add/sub, accumulate, row-serial matvec.
// SIMD_ARR_PIPE_SAT_EN: signed saturating ADD/SUB/ACC plus per-lane o_sat flags.
module simd_arr_pipe
  import simd_pkg::*;
#(
  parameter int UNIT_SIZE = DEF_UNIT_SIZE,
  parameter int LANES     = DEF_LANES,
  parameter int MAT_DIM   = DEF_MAT_DIM
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [2:0]                       i_opcode,   // opcode_t encoding
  input  logic [UNIT_SIZE*LANES-1:0]       i_in1,
  input  logic [UNIT_SIZE*LANES-1:0]       i_in2,
  input  logic [UNIT_SIZE*MAT_DIM*MAT_DIM-1:0] i_mat,
  output logic                             o_valid,
  input  logic                             i_res_ready,
  output logic [UNIT_SIZE*LANES-1:0]       o_res,
  output logic                             o_busy
`ifdef SIMD_ARR_PIPE_SAT_EN
  ,
  output logic [LANES-1:0]                 o_sat
`endif
);

  localparam int RW = (MAT_DIM > 1) ? $clog2(MAT_DIM) : 1;

  if (MAT_DIM < 1 || MAT_DIM > LANES) begin : g_bad_dim
    $error("simd_arr_pipe: MAT_DIM must be within 1..LANES");
  end

  typedef logic [LANES-1:0][UNIT_SIZE-1:0]               vec_t;
  typedef logic [MAT_DIM-1:0][MAT_DIM-1:0][UNIT_SIZE-1:0] mat_t;

  vec_t   in1, in2, res_q, acc_q, nxt_res, add_l, sub_l, accn_l;
  mat_t   mat_q;
  logic [MAT_DIM-1:0][UNIT_SIZE-1:0] vec_q;
  logic [UNIT_SIZE-1:0] dot;
  logic [RW-1:0]        row_q;
  state_t               state_q;
  logic                 vld_q, accept;

  assign in1 = i_in1;
  assign in2 = i_in2;

`ifdef SIMD_ARR_PIPE_SAT_EN
  localparam logic [UNIT_SIZE-1:0] SMAX = {1'b0, {(UNIT_SIZE-1){1'b1}}};
  localparam logic [UNIT_SIZE-1:0] SMIN = {1'b1, {(UNIT_SIZE-1){1'b0}}};
  logic [LANES-1:0] add_s, sub_s, acc_s, nxt_sat, sat_q;

  // One guard bit: overflow whenever it disagrees with the result sign.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [UNIT_SIZE:0] add_w, sub_w, acc_w;
    assign add_w = {in1[k][UNIT_SIZE-1], in1[k]} + {in2[k][UNIT_SIZE-1], in2[k]};
    assign sub_w = {in1[k][UNIT_SIZE-1], in1[k]} - {in2[k][UNIT_SIZE-1], in2[k]};
    assign acc_w = {acc_q[k][UNIT_SIZE-1], acc_q[k]} + {in1[k][UNIT_SIZE-1], in1[k]};
    assign add_s[k]  = add_w[UNIT_SIZE] ^ add_w[UNIT_SIZE-1];
    assign sub_s[k]  = sub_w[UNIT_SIZE] ^ sub_w[UNIT_SIZE-1];
    assign acc_s[k]  = acc_w[UNIT_SIZE] ^ acc_w[UNIT_SIZE-1];
    assign add_l[k]  = add_s[k] ? (add_w[UNIT_SIZE] ? SMIN : SMAX) : add_w[UNIT_SIZE-1:0];
    assign sub_l[k]  = sub_s[k] ? (sub_w[UNIT_SIZE] ? SMIN : SMAX) : sub_w[UNIT_SIZE-1:0];
    assign accn_l[k] = acc_s[k] ? (acc_w[UNIT_SIZE] ? SMIN : SMAX) : acc_w[UNIT_SIZE-1:0];
  end

  assign o_sat = sat_q;
`else
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign add_l[k]  = in1[k] + in2[k];
    assign sub_l[k]  = in1[k] - in2[k];
    assign accn_l[k] = acc_q[k] + in1[k];
  end
`endif

  always_comb begin
    nxt_res = '0;
`ifdef SIMD_ARR_PIPE_SAT_EN
    nxt_sat = '0;
`endif
    case (i_opcode)
      OP_ADD: begin
        nxt_res = add_l;
`ifdef SIMD_ARR_PIPE_SAT_EN
        nxt_sat = add_s;
`endif
      end
      OP_SUB: begin
        nxt_res = sub_l;
`ifdef SIMD_ARR_PIPE_SAT_EN
        nxt_sat = sub_s;
`endif
      end
      OP_ACC: begin
        nxt_res = accn_l;
`ifdef SIMD_ARR_PIPE_SAT_EN
        nxt_sat = acc_s;
`endif
      end
      OP_ACC_CLR: nxt_res = in1;
      default:    nxt_res = '0;
    endcase
  end

  simd_dot_row #(.UNIT_SIZE(UNIT_SIZE), .MAT_DIM(MAT_DIM)) u_dot (
    .row (mat_q[row_q]),
    .vec (vec_q),
    .dot (dot)
  );

  // Gated by reset so upstream never sees a ready while the block is held.
  assign o_ready = i_rst_n && (state_q == IDLE) && (!vld_q || i_res_ready);
  assign accept  = i_valid && o_ready;
  assign o_valid = vld_q;
  assign o_busy  = (state_q == MV);
  assign o_res   = res_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      vld_q   <= 1'b0;
      mat_q   <= '0;
      vec_q   <= '0;
`ifdef SIMD_ARR_PIPE_SAT_EN
      sat_q   <= '0;
`endif
    end else begin
      if (vld_q && i_res_ready) vld_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          if (i_opcode == OP_MATVEC) begin
            state_q <= MV;
            row_q   <= '0;
            res_q   <= '0;
            mat_q   <= i_mat;
            vec_q   <= in2[MAT_DIM-1:0];
`ifdef SIMD_ARR_PIPE_SAT_EN
            sat_q   <= '0;
`endif
          end else begin
            res_q <= nxt_res;
            vld_q <= 1'b1;
`ifdef SIMD_ARR_PIPE_SAT_EN
            sat_q <= nxt_sat;
`endif
            if (i_opcode == OP_ACC)     acc_q <= accn_l;
            if (i_opcode == OP_ACC_CLR) acc_q <= in1;
          end
        end
        MV: begin
          for (int k = 0; k < MAT_DIM; k++)
            if (row_q == RW'(k)) res_q[k] <= dot;
          if (row_q == RW'(MAT_DIM-1)) begin
            state_q <= IDLE;
            row_q   <= '0;
            vld_q   <= 1'b1;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/simd_arr_pipe.md
Name: simd_arr_pipe

Overview:
Registered, handshaked successor to the combinational 3x3 SIMD array. Performs lane-wise add/sub, persistent accumulate, and MAT_DIM x MAT_DIM matrix-vector multiply over LANES lanes of UNIT_SIZE bits. Matvec runs sequentially, one row per cycle through a single dot-product row unit, so multiplier count is MAT_DIM rather than MAT_DIM^2. Sits between the operand fetch stage and the writeback/result buffer of the SIMD multiprocessor datapath.

Parameters:
UNIT_SIZE, 32, lane width in bits
LANES, 8, number of lanes in i_in1/i_in2/o_res
MAT_DIM, 3, matrix dimension; legal range 1..LANES, checked at elaboration

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  command valid
o_ready  out  1  block can accept a command
i_opcode  in  3  simd_pkg::opcode_t
i_in1  in  UNIT_SIZE*LANES  operand A; lane k at bits [(k+1)*UNIT_SIZE-1 : k*UNIT_SIZE]
i_in2  in  UNIT_SIZE*LANES  operand B; matvec vector in lanes 0..MAT_DIM-1
i_mat  in  UNIT_SIZE*MAT_DIM*MAT_DIM  matrix, row-major; element (r,c) at index r*MAT_DIM+c
o_valid  out  1  result valid
i_res_ready  in  1  downstream accepts result
o_res  out  UNIT_SIZE*LANES  result, same lane packing
o_busy  out  1  matvec in progress

Behaviour:
- Reset (async, active-low): state=IDLE, row counter=0, accumulator=0, o_res=0, o_valid=0, o_busy=0. o_ready=0 while i_rst_n is low. Reset mid-matvec aborts the operation; no partial result is emitted.
- o_ready = (state==IDLE) && (!o_valid || i_res_ready). A command is accepted on a rising edge with i_valid && o_ready. On that edge all operands are latched.
- Result handshake: o_valid and o_res stay stable until an edge with i_res_ready=1. If a new result loads on the same edge as the consume, o_valid stays 1 with new data. If not, o_valid falls.
- OP_ADD(0) / OP_SUB(1): per-lane in1+/-in2 modulo 2^UNIT_SIZE. The result registers on the accept edge, so o_valid=1 in the cycle after acceptance (latency 1). Back-to-back throughput is 1 per cycle when i_res_ready=1.
- OP_ACC(3): acc <= acc + in1 per lane (wrapping). o_res <= new acc. Latency 1.
- OP_ACC_CLR(4): acc <= in1. o_res <= in1. Latency 1.
- OP_MATVEC(2): on the accept edge, state goes IDLE->MV with row=0; o_busy=1 and o_valid drops (old result already consumed).
  - Each MV edge writes lane[row] = sum over c of mat(row,c)*vec[c]. Products and sums are truncated to UNIT_SIZE bits, wrapping.
  - Row increments each edge. The edge that writes row MAT_DIM-1 returns the state to IDLE and sets o_valid=1 with o_busy=0.
  - o_valid rises MAT_DIM edges after the accept edge.
  - Lanes MAT_DIM..LANES-1 are 0.
  - i_valid is ignored while in MV.
- Opcodes 5..7: accepted. Produce an all-zero result with latency 1, acc unchanged.
- The accumulator is affected only by ACC/ACC_CLR and reset.

Optional Feature:
SIMD_ARR_PIPE_SAT_EN. When defined:
- ADD, SUB and ACC treat lanes as signed two's complement and saturate to [-2^(UNIT_SIZE-1), 2^(UNIT_SIZE-1)-1].
- An extra output o_sat (LANES bits) flags the lanes that saturated, registered alongside o_res.

When undefined: all arithmetic wraps and the o_sat port does not exist. Matvec always wraps in both builds.

Decomposition:
- Package simd_pkg:
  - opcode_t enum (OP_ADD=3'd0, OP_SUB=3'd1, OP_MATVEC=3'd2, OP_ACC=3'd3, OP_ACC_CLR=3'd4)
  - state enum (IDLE, MV)
  - default UNIT_SIZE/LANES/MAT_DIM localparams
- One sub-module, simd_dot_row: combinational MAT_DIM-element multiply plus adder tree, parametrised by UNIT_SIZE and MAT_DIM, instantiated once.

Test Plan:
- Reset, then ADD with in1 lane k = k, in2 lane k = 10 -> o_valid rises the cycle after accept; o_res lane k = k+10.
- SUB with lane0 0 - 1 -> 0xFFFFFFFF. With SIMD_ARR_PIPE_SAT_EN, ADD 0x7FFFFFFF + 1 -> 0x7FFFFFFF and o_sat[0]=1.
- MATVEC with mat=[[1,2,3],[4,5,6],[7,8,9]], vec=[1,1,1] -> o_res lanes 0..2 = 6,15,24, lanes 3..7 = 0. o_valid rises 3 edges after accept; o_ready=0 and o_busy=1 during the 3 edges.
- Backpressure: hold i_res_ready=0 after an ADD result -> o_res stable, o_ready=0, and a further i_valid is not accepted. Release -> next command accepted on the same edge the result is consumed.
- ACC_CLR with in1 = 5 in all lanes, then ACC with 3, then ACC with 3 -> results 5, 8, 11.
- Assert i_rst_n low mid-MATVEC (after row 1) -> o_valid=0, o_busy=0, acc=0 immediately. A subsequent ADD behaves normally.
